// File: rtl/sidebar_pkg.sv
// Shared definitions for the cake stack tracker: colour codes, stack
// geometry, the tracker state encoding and the recipe colour map.
package sidebar_pkg;

    localparam int         LAYER_W     = 3;
    localparam int         STACK_SLOTS = 6;
    localparam logic [2:0] COL_NONE    = 3'b000;
    localparam logic [2:0] COL_CHERRY  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        EVAL,
        SHOW,
        NEWREC
    } tracker_state_e;

    // Recipe layers must be a real cake colour: never empty, never cherry.
    function automatic logic [LAYER_W-1:0] map_colour(input logic [LAYER_W-1:0] raw);
        logic [LAYER_W-1:0] mapped;
        mapped = raw;
        if (raw == COL_NONE) begin
            mapped = 3'b001;
        end else if (raw == COL_CHERRY) begin
            mapped = 3'b110;
        end
        return mapped;
    endfunction

endpackage

// File: rtl/cake_stack_tracker_if.sv
// Bundle between the catch logic, the tracker and the sidebar renderer.
// The master side drives catches and the sidebar idle flag; the slave side
// (the tracker) returns the stack, recipe and scoring outputs.
interface cake_stack_tracker_if;
    import sidebar_pkg::*;

    logic                             catch_valid;
    logic [LAYER_W-1:0]               catch_colour;
    logic                             sidebar_draw_done;
    logic [LAYER_W*STACK_SLOTS-1:0]   cake_caught;
    logic [LAYER_W*STACK_SLOTS-1:0]   recipe;
    logic                             order_done;
    logic                             order_correct;
    logic [7:0]                       score;
    logic                             busy;

    modport master (
        output catch_valid, catch_colour, sidebar_draw_done,
        input  cake_caught, recipe, order_done, order_correct, score, busy
    );

    modport slave (
        input  catch_valid, catch_colour, sidebar_draw_done,
        output cake_caught, recipe, order_done, order_correct, score, busy
    );
endinterface

// File: rtl/cake_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) plus the recipe
// colour map applied to its low three bits.
module cake_lfsr
    import sidebar_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               clock,
    input  logic               resetn,
    output logic [LAYER_W-1:0] colour_o
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Shift left, feeding back the XOR of taps 8, 6, 5 and 4.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Advance every cycle; the seed is reloaded while reset is held.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign colour_o = map_colour(lfsr_q[2:0]);
endmodule

// File: rtl/cake_stack_tracker.sv
// Cake stack tracker: builds the caught stack one layer per catch, generates
// random recipes, scores finished orders and only changes its visible state
// while the sidebar reports idle.
// Optional build macro SCORE_PENALTY_EN: a wrong order decrements the score
// (floored at 0); without it wrong orders leave the score alone.
module cake_stack_tracker
    import sidebar_pkg::*;
#(
    parameter int         NUM_LAYERS  = 5,
    parameter int         HOLD_CYCLES = 50_000_000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic                 clock,
    input  logic                 resetn,
    cake_stack_tracker_if.slave  bus
);
    localparam int                STACK_W   = LAYER_W * STACK_SLOTS;
    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    // Step 0 clears, steps 1..NUM_LAYERS fill layers, the last step adds the cherry.
    localparam logic [2:0]        STEP_LAST = 3'(NUM_LAYERS + 1);

    tracker_state_e      state_q, state_d;
    logic [STACK_W-1:0]  cake_q, cake_d;
    logic [STACK_W-1:0]  recipe_q, recipe_d;
    logic [2:0]          depth_q, depth_d;
    logic [LAYER_W-1:0]  pend_q, pend_d;
    logic [2:0]          step_q, step_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [7:0]          score_q, score_d;

    logic [LAYER_W-1:0]     lfsr_colour;
    logic [STACK_SLOTS-1:0] push_sel;
    logic [STACK_SLOTS-1:0] gen_sel;
    logic [STACK_W-1:0]     gen_val;
    logic                   catch_hit;
    logic                   commit_en;
    logic [LAYER_W-1:0]     commit_colour;
    logic                   commit_last;
    logic                   stack_match;
    logic                   hold_done;

    cake_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clock    (clock),
        .resetn   (resetn),
        .colour_o (lfsr_colour)
    );

    // Per-slot decode: which slot a catch lands in, which slot the current
    // recipe step writes, and what that step writes (cherry above the layers).
    genvar gi;
    generate
        for (gi = 0; gi < STACK_SLOTS; gi++) begin : g_slot
            assign push_sel[gi] = (depth_q == 3'(gi));
            assign gen_sel[gi]  = (step_q == 3'(gi + 1));
            assign gen_val[gi*LAYER_W +: LAYER_W] = (gi == NUM_LAYERS) ? COL_CHERRY : lfsr_colour;
        end
    endgenerate

    assign catch_hit     = bus.catch_valid && (bus.catch_colour != COL_NONE);
    assign commit_en     = bus.sidebar_draw_done &&
                           (((state_q == IDLE) && catch_hit) || (state_q == PEND));
    assign commit_colour = (state_q == PEND) ? pend_q : bus.catch_colour;
    assign commit_last   = (commit_colour == COL_CHERRY) || (depth_q == 3'(STACK_SLOTS - 1));
    assign stack_match   = (cake_q == recipe_q);
    assign hold_done     = (hold_q == HOLD_LAST);

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= NEWREC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (catch_hit && !bus.sidebar_draw_done) begin
                    state_d = PEND;
                end else if (commit_en && commit_last) begin
                    state_d = EVAL;
                end
            end
            PEND: begin
                if (commit_en) begin
                    state_d = commit_last ? EVAL : IDLE;
                end
            end
            EVAL:   state_d = SHOW;
            SHOW: begin
                if (hold_done) begin
                    state_d = NEWREC;
                end
            end
            NEWREC: begin
                if (bus.sidebar_draw_done && (step_q == STEP_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: stack commits, recipe generation, hold timer, score.
    always_comb begin
        cake_d   = cake_q;
        recipe_d = recipe_q;
        depth_d  = depth_q;
        pend_d   = pend_q;
        step_d   = step_q;
        hold_d   = hold_q;
        score_d  = score_q;
        case (state_q)
            IDLE: begin
                if (catch_hit && !bus.sidebar_draw_done) begin
                    pend_d = bus.catch_colour;
                end
            end
            EVAL: begin
                if (stack_match) begin
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end
`ifdef SCORE_PENALTY_EN
                else if (score_q != 8'h00) begin
                    score_d = score_q - 8'd1;
                end
`endif
            end
            SHOW: begin
                hold_d = hold_done ? '0 : hold_q + HOLD_W'(1);
            end
            NEWREC: begin
                if (bus.sidebar_draw_done) begin
                    if (step_q == 3'd0) begin
                        cake_d   = '0;
                        recipe_d = '0;
                        depth_d  = '0;
                    end else begin
                        for (int k = 0; k < STACK_SLOTS; k++) begin
                            if (gen_sel[k]) begin
                                recipe_d[k*LAYER_W +: LAYER_W] = gen_val[k*LAYER_W +: LAYER_W];
                            end
                        end
                    end
                    step_d = (step_q == STEP_LAST) ? 3'd0 : step_q + 3'd1;
                end
            end
            default: ;
        endcase
        if (commit_en) begin
            for (int k = 0; k < STACK_SLOTS; k++) begin
                if (push_sel[k]) begin
                    cake_d[k*LAYER_W +: LAYER_W] = commit_colour;
                end
            end
            depth_d = depth_q + 3'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cake_q   <= '0;
            recipe_q <= '0;
            depth_q  <= '0;
            pend_q   <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            score_q  <= '0;
        end else begin
            cake_q   <= cake_d;
            recipe_q <= recipe_d;
            depth_q  <= depth_d;
            pend_q   <= pend_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            score_q  <= score_d;
        end
    end

    // Outputs; busy is forced low while reset is asserted so every output reads 0.
    always_comb begin
        bus.cake_caught   = cake_q;
        bus.recipe        = recipe_q;
        bus.score         = score_q;
        bus.order_done    = (state_q == EVAL);
        bus.order_correct = (state_q == EVAL) && stack_match;
        bus.busy          = resetn && (state_q != IDLE) && (state_q != PEND);
    end
endmodule

// File: tb/tb_cake_stack_tracker.sv
// Testbench for cake_stack_tracker: directed scenarios plus random catches,
// every cycle compared against a behavioural model of stack, recipe and score.
module tb_cake_stack_tracker;
    localparam int HOLD = 4;
    localparam int NL   = 5;

    localparam int PH_GEN   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_PEND  = 2;
    localparam int PH_JUDGE = 3;
    localparam int PH_HOLD  = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cake_stack_tracker_if bus();

    cake_stack_tracker #(
        .NUM_LAYERS  (NL),
        .HOLD_CYCLES (HOLD),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int         m_stack [6];
    int         m_recipe[6];
    int         m_depth, m_score, m_pend, m_gen, m_hold, m_phase;
    logic [7:0] m_lfsr;

    function automatic int model_map(input logic [7:0] r);
        int v;
        v = int'(r[2:0]);
        if (v == 0) return 1;
        if (v == 7) return 6;
        return v;
    endfunction

    function automatic bit stacks_equal();
        for (int k = 0; k < 6; k++) begin
            if (m_stack[k] != m_recipe[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_commit(input int c);
        m_stack[m_depth] = c;
        m_depth++;
        m_phase = (c == 7 || m_depth == 6) ? PH_JUDGE : PH_WAIT;
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 6; k++) begin
                m_stack[k]  = 0;
                m_recipe[k] = 0;
            end
            m_depth = 0; m_score = 0; m_pend = 0; m_gen = 0; m_hold = 0;
            m_phase = PH_GEN;
            m_lfsr  = 8'hA5;
        end else begin
            case (m_phase)
                PH_GEN: if (bus.sidebar_draw_done) begin
                    if (m_gen == 0) begin
                        for (int k = 0; k < 6; k++) begin
                            m_stack[k]  = 0;
                            m_recipe[k] = 0;
                        end
                        m_depth = 0;
                        m_gen   = 1;
                    end else if (m_gen <= NL) begin
                        m_recipe[m_gen-1] = model_map(m_lfsr);
                        m_gen++;
                    end else begin
                        m_recipe[NL] = 7;
                        m_gen   = 0;
                        m_phase = PH_WAIT;
                    end
                end
                PH_WAIT: if (bus.catch_valid && bus.catch_colour != 3'b000) begin
                    if (bus.sidebar_draw_done) model_commit(int'(bus.catch_colour));
                    else begin
                        m_pend  = int'(bus.catch_colour);
                        m_phase = PH_PEND;
                    end
                end
                PH_PEND: if (bus.sidebar_draw_done) model_commit(m_pend);
                PH_JUDGE: begin
                    if (stacks_equal()) m_score = (m_score < 255) ? m_score + 1 : 255;
`ifdef SCORE_PENALTY_EN
                    else m_score = (m_score > 0) ? m_score - 1 : 0;
`endif
                    m_hold  = 0;
                    m_phase = PH_HOLD;
                end
                default: begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        m_gen   = 0;
                        m_phase = PH_GEN;
                    end
                end
            endcase
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [17:0] exp_cake, exp_rec;
    logic        exp_busy;

    always @(negedge clock) begin
        for (int k = 0; k < 6; k++) begin
            exp_cake[k*3 +: 3] = 3'(m_stack[k]);
            exp_rec[k*3 +: 3]  = 3'(m_recipe[k]);
        end
        exp_busy = resetn && (m_phase != PH_WAIT) && (m_phase != PH_PEND);
        check("cake_caught", 32'(bus.cake_caught), 32'(exp_cake));
        check("recipe", 32'(bus.recipe), 32'(exp_rec));
        check("score", 32'(bus.score), 32'(m_score));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("order_done", 32'(bus.order_done), 32'(m_phase == PH_JUDGE));
        check("order_correct", 32'(bus.order_correct), 32'(m_phase == PH_JUDGE && stacks_equal()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [2:0] c);
        bus.catch_valid  = 1'b1;
        bus.catch_colour = c;
        @(negedge clock);
        bus.catch_valid  = 1'b0;
        bus.catch_colour = 3'b000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("wait_idle_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic do_correct();
        wait_idle();
        for (int i = 0; i < NL; i++) push(3'(m_recipe[i]));
        push(3'b111);
    endtask

    task automatic do_wrong();
        wait_idle();
        push(3'b001);
        push(3'b010);
        push(3'b111);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        logic [17:0] rec;
        bus.catch_valid       = 1'b0;
        bus.catch_colour      = 3'b000;
        bus.sidebar_draw_done = 1'b1;
        resetn                = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_cake", 32'(bus.cake_caught), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        // Release and measure the initial recipe generation time.
        #2 resetn = 1'b1;
        #1;
        bc = 0;
        while (bus.busy === 1'b1 && bc < 50) begin
            bc++;
            @(negedge clock);
        end
        check("busy_cycles_after_reset", 32'(bc), 32'd7);
        rec = bus.recipe;
        check("first_recipe", 32'(rec), 32'h398AA);
        check("recipe_cherry", 32'(rec[17:15]), 32'd7);
        for (int k = 0; k < NL; k++) begin
            check("recipe_layer_legal", 32'(rec[k*3 +: 3] != 3'b000 && rec[k*3 +: 3] != 3'b111), 32'd1);
        end

        // Correct order.
        do_correct();
        check("correct_done", 32'(bus.order_done), 32'd1);
        check("correct_flag", 32'(bus.order_correct), 32'd1);
        @(negedge clock);
        check("score_after_first", 32'(bus.score), 32'd1);
        wait_idle();
        check("cleared_after_show", 32'(bus.cake_caught), 32'd0);

        // Wrong orders, then three right, then one wrong.
        do_wrong();
        check("wrong_done", 32'(bus.order_done), 32'd1);
        check("wrong_flag", 32'(bus.order_correct), 32'd0);
        do_wrong();
        @(negedge clock);
`ifdef SCORE_PENALTY_EN
        check("score_after_wrong", 32'(bus.score), 32'd0);
`else
        check("score_after_wrong", 32'(bus.score), 32'd1);
`endif
        repeat (3) do_correct();
        do_wrong();
        @(negedge clock);
`ifdef SCORE_PENALTY_EN
        check("score_penalty_from3", 32'(bus.score), 32'd2);
`else
        check("score_no_penalty", 32'(bus.score), 32'd4);
`endif

        // Sidebar busy: buffer one item, drop the second.
        wait_idle();
        bus.sidebar_draw_done = 1'b0;
        push(3'b011);
        push(3'b101);
        repeat (2) @(negedge clock);
        check("pend_hidden", 32'(bus.cake_caught), 32'd0);
        bus.sidebar_draw_done = 1'b1;
        @(negedge clock);
        check("pend_committed", 32'(bus.cake_caught), 32'h3);
        push(3'b000);
        @(negedge clock);
        check("none_ignored", 32'(bus.cake_caught), 32'h3);
        push(3'b111);
        for (int i = 1; i <= 5; i++) push(3'(i));
        check("drop_in_show", 32'(bus.cake_caught), 32'h3B);
        for (int i = 0; i < 7; i++) push(3'(1 + (i % 6)));
        wait_idle();
        check("cleared_after_drops", 32'(bus.cake_caught), 32'd0);

        // Random catches and sidebar activity.
        for (int i = 0; i < 400; i++) begin
            bus.catch_valid       = ($urandom_range(0, 2) == 0);
            bus.catch_colour      = 3'($urandom_range(0, 7));
            bus.sidebar_draw_done = ($urandom_range(0, 3) != 0);
            @(negedge clock);
        end
        bus.catch_valid       = 1'b0;
        bus.catch_colour      = 3'b000;
        bus.sidebar_draw_done = 1'b1;

        // Restart, then saturate the score.
        #2 resetn = 1'b0;
        repeat (2) @(negedge clock);
        #2 resetn = 1'b1;
        for (int n = 0; n < 260 && m_score < 255; n++) do_correct();
        @(negedge clock);
        check("score_saturated", 32'(bus.score), 32'd255);
        do_correct();
        check("sat_order_correct", 32'(bus.order_correct), 32'd1);
        @(negedge clock);
        check("score_holds_255", 32'(bus.score), 32'd255);

        // Asynchronous reset in the middle of SHOW.
        do_correct();
        repeat (2) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("async_cake", 32'(bus.cake_caught), 32'd0);
        check("async_recipe", 32'(bus.recipe), 32'd0);
        check("async_score", 32'(bus.score), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_done", 32'(bus.order_done), 32'd0);
        check("async_correct", 32'(bus.order_correct), 32'd0);
        @(negedge clock);
        #2 resetn = 1'b1;
        wait_idle();
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cake_stack_tracker.md
Name: cake_stack_tracker

Overview:
- Producer of the `cake_caught` and `recipe` vectors that the sidebar renderer consumes.
- Builds the caught-cake stack one layer per catch event and generates random recipes.
- Evaluates each finished order against its recipe and keeps the score.
- Changes its outputs only while the sidebar is idle (`sidebar_draw_done` high), so a frame never renders a half-updated stack.

Parameters:
- `NUM_LAYERS`, 5: cake layers per recipe, legal range 1..5. The cherry sits in slot `NUM_LAYERS`; higher slots are 000.
- `HOLD_CYCLES`, 50_000_000: cycles the completed stack stays displayed before the next recipe.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clock`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `catch_valid`  in  1  one-cycle pulse: an item landed on the plate
- `catch_colour`  in  3  colour of the landed item; 111 = cherry, 000 = none (ignored)
- `sidebar_draw_done`  in  1  high = sidebar idle, outputs may change
- `cake_caught`  out  18  stack; slot k in bits [3k+2:3k], slot 0 = bottom
- `recipe`  out  18  target stack, same packing
- `order_done`  out  1  one-cycle pulse when an order is evaluated
- `order_correct`  out  1  one-cycle pulse, coincident with `order_done`, asserted only on an exact match
- `score`  out  8  count of correct orders, saturates at 255
- `busy`  out  1  high in every state except IDLE and PEND

Behaviour:
- Reset (asynchronous, `resetn` low): all outputs 0, depth 0, LFSR = `LFSR_SEED`, state = NEWREC, pending buffer empty. Release mid-operation restarts from this point.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, free-running (advances every cycle).
- Colour map from `lfsr[2:0]`: 000→001, 111→110, any other value passes through unchanged. Recipe cake layers are therefore never empty and never cherry.
- State IDLE:
  - `catch_valid` with colour 000 is ignored.
  - Nonzero catch with `sidebar_draw_done`=1: COMMIT on the next edge.
  - Nonzero catch with `sidebar_draw_done`=0: latch the colour, go to PEND.
- State PEND:
  - Holds one buffered item; commits on the first cycle `sidebar_draw_done`=1.
  - Further `catch_valid` pulses while in PEND are dropped.
- COMMIT action:
  - Writes the colour into slot `depth`; `depth` += 1; visible on `cake_caught` the cycle after the commit edge.
  - If the colour is 111 or the new depth is 6, go to EVAL; otherwise return to IDLE.
- State EVAL (1 cycle):
  - Correct iff `cake_caught` == `recipe` (all 18 bits).
  - Pulse `order_done`; pulse `order_correct` if correct.
  - If correct, `score` += 1, saturating at 255.
  - Go to SHOW.
- State SHOW:
  - Counts `HOLD_CYCLES`; catches are dropped.
  - At terminal count, go to NEWREC.
- State NEWREC:
  - Stalls on any cycle with `sidebar_draw_done`=0.
  - First active cycle: clear `cake_caught`, `recipe` and `depth`.
  - Next `NUM_LAYERS` active cycles: slot i (i = 0..`NUM_LAYERS`-1) receives the mapped colour.
  - Next active cycle: slot `NUM_LAYERS` = 111, then go to IDLE.
  - Catches are dropped throughout.
- Simultaneous events: a catch arriving in the same cycle as the IDLE→EVAL path is impossible (COMMIT leaves IDLE). A catch in EVAL is dropped.
- A recipe's upper slots stay 000, so the sidebar stops drawing at the cherry.

Optional Feature:
- Macro: `SCORE_PENALTY_EN`.
- Defined: an incorrect order decrements `score` by 1, floored at 0.
- Undefined: incorrect orders leave `score` unchanged.
- `order_done` and `order_correct` behave identically in both builds.

Decomposition:
- Shared package `sidebar_pkg`:
  - Constants: `COL_NONE`=3'b000, `COL_CHERRY`=3'b111, `LAYER_W`=3, `STACK_SLOTS`=6.
  - Tracker state enum: IDLE, PEND, EVAL, SHOW, NEWREC.
- Sub-module `cake_lfsr`: 8-bit LFSR plus the colour map, exporting the mapped `colour[2:0]`.
- The FSM, stack register, hold counter and score logic stay in the top.

Test Plan (bench uses `HOLD_CYCLES`=4, `NUM_LAYERS`=5, `sidebar_draw_done` tied to 1 unless noted):
- Reset release → `busy` stays 1 for exactly 7 cycles, then IDLE. `recipe[17:15]`=111; slots 0-4 match a reference-model LFSR (seed A5) and each is in 001..110.
- Push the 5 recipe colours, then 111 → `order_done`=`order_correct`=1 for one cycle; `score`=1; `cake_caught`==`recipe` held 4 cycles, then cleared and a new recipe generated.
- Push 001, 010, then 111 against a different recipe → `order_done`=1, `order_correct`=0, `score` unchanged. With `SCORE_PENALTY_EN` and starting `score`=0, `score` stays 0; starting at 3, `score` becomes 2.
- `sidebar_draw_done`=0, pulse `catch_valid` with 011, then pulse again with 101 → `cake_caught` unchanged while low. On raise, slot 0=011 only; the 101 is dropped.
- `catch_colour`=000 pulse, and catches during SHOW/NEWREC → no change to `cake_caught` or `depth`.
- 255 correct orders then one more → `score` holds 255. Assert `resetn` low mid-SHOW → every output 0 immediately (asynchronous), no `order_done` pulse.
